// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multicycle RV32I control path: controller state
// encoding, the ALU operation class handed to the ALU decoder, the opcodes
// the controller recognises, and the alucontrol / immsrc encodings.
// Ports: none (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format is a pure function of the opcode; unknown opcodes
   // fall back to the I format so the extender never sees an undefined select.
   function automatic logic [1:0] imm_fmt(input logic [6:0] op);
      logic [1:0] fmt;
      case (op)
         OP_SW:   fmt = IMM_S;
         OP_BEQ:  fmt = IMM_B;
         OP_JAL:  fmt = IMM_J;
         default: fmt = IMM_I;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU-control decode shared by the multicycle and pipelined
// cores. Turns the controller's ALU operation class plus instruction fields
// into the 3-bit ALU function select.
// Ports:
//   aluop_i      in  2  operation class: add, sub, or decode from funct fields
//   funct3_i     in  3  IR[14:12]
//   funct7b5_i   in  1  IR[30]
//   op5_i        in  1  IR[5], distinguishes R-type from I-type ALU ops
//   alucontrol_o out 3  ALU function select
// -----------------------------------------------------------------------------
module alu_decoder
   import riscv_pkg::*;
(
   input  aluop_t     aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alucontrol_o
);

   always_comb begin
      alucontrol_o = ALU_ADD;
      case (aluop_i)
         ALUOP_ADD: alucontrol_o = ALU_ADD;
         ALUOP_SUB: alucontrol_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // IR[30] only selects sub for register-register ops; for addi
               // that bit belongs to the immediate.
               3'b000:  alucontrol_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol_o = ALU_SLT;
               3'b110:  alucontrol_o = ALU_OR;
               3'b111:  alucontrol_o = ALU_AND;
               default: alucontrol_o = ALU_ADD;
            endcase
         end
         default: alucontrol_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for the multicycle RV32I core. Sequences the shared datapath
// through fetch / decode / execute / memory / writeback, decodes the immediate
// format from the opcode and stalls on the memory ready handshake.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   op, funct3, funct7b5 instruction fields from IR
//   zero                ALU zero flag (branch resolution)
//   mem_ready           memory completes the current access this cycle
//   pcwrite, irwrite, memwrite, regwrite  datapath write enables
//   adrsrc, resultsrc, alusrca, alusrcb, immsrc  datapath mux selects
//   alucontrol          ALU function select
//   illegal_instr       one-cycle pulse on an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_controller
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] immsrc,
   output logic       regwrite,
   output logic [2:0] alucontrol,
   output logic       illegal_instr
);

   state_t state_q, state_d;
   aluop_t aluop;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      pcwrite       = 1'b0;
      adrsrc        = 1'b0;
      memwrite      = 1'b0;
      irwrite       = 1'b0;
      resultsrc     = 2'b00;
      alusrca       = 2'b00;
      alusrcb       = 2'b00;
      regwrite      = 1'b0;
      illegal_instr = 1'b0;
      aluop         = ALUOP_ADD;

      case (state_q)
         S_FETCH: begin
            // PC+4 computed while the instruction is read; both PC and IR
            // commit only when memory delivers.
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            irwrite   = mem_ready;
            pcwrite   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Branch target OldPC+imm is precomputed into ALUOut here.
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adrsrc = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            // Strobe stays up for the whole access, not just the last cycle.
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            alusrca = 2'b10;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQ: begin
            // Compare rs1-rs2; PC takes the target held in ALUOut when equal.
            alusrca = 2'b10;
            aluop   = ALUOP_SUB;
            pcwrite = zero;
            state_d = S_FETCH;
         end
         S_JAL: begin
            // PC <= target from ALUOut while the ALU forms OldPC+4 for rd.
            alusrca = 2'b01;
            alusrcb = 2'b10;
            pcwrite = 1'b1;
            state_d = S_ALUWB;
         end
         S_ILLEGAL: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset abandons any in-flight instruction without side effects.
      if (reset) begin
         pcwrite       = 1'b0;
         memwrite      = 1'b0;
         irwrite       = 1'b0;
         regwrite      = 1'b0;
         illegal_instr = 1'b0;
      end
   end

   assign immsrc = imm_fmt(op);

   alu_decoder u_alu_decoder (
      .aluop_i      (aluop),
      .funct3_i     (funct3),
      .funct7b5_i   (funct7b5),
      .op5_i        (op[5]),
      .alucontrol_o (alucontrol)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Randomized scoreboard bench. The stimulus process walks each instruction
// through its architectural steps, pushing the control word expected in each
// cycle; a negedge monitor pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
   // enables: pcwrite, memwrite, irwrite, regwrite, illegal_instr
   localparam logic [16:0] EN_MASK = 17'b1_0_1_1_00_00_00_00_1_000_1;
   localparam logic [16:0] ALL     = '1;

   logic       clk = 1'b0;
   logic       reset, funct7b5, zero, mem_ready;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_instr;
   logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
   logic [2:0] alucontrol;
   logic [16:0] dut_vec;

   typedef struct {
      logic [16:0] exp;
      logic [16:0] msk;
      string       tag;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   fetch_stalls = -1;
   int   mem_stalls   = -1;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk           (clk),
      .reset         (reset),
      .op            (op),
      .funct3        (funct3),
      .funct7b5      (funct7b5),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pcwrite       (pcwrite),
      .adrsrc        (adrsrc),
      .memwrite      (memwrite),
      .irwrite       (irwrite),
      .resultsrc     (resultsrc),
      .alusrca       (alusrca),
      .alusrcb       (alusrcb),
      .immsrc        (immsrc),
      .regwrite      (regwrite),
      .alucontrol    (alucontrol),
      .illegal_instr (illegal_instr)
   );

   assign dut_vec = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca,
                     alusrcb, immsrc, regwrite, alucontrol, illegal_instr};

   // Monitor: one expected control word per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         n_checks++;
         if (((dut_vec ^ cur.exp) & cur.msk) == 17'd0) n_pass++;
         else $display("FAIL %s: got %05h required %05h (mask %05h)",
                       cur.tag, dut_vec, cur.exp, cur.msk);
      end
   end

   function automatic logic [16:0] mk(input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic [1:0] res,
      input logic [1:0] sa, input logic [1:0] sbb, input logic [1:0] imm,
      input logic rw, input logic [2:0] alu, input logic ill);
      return {pcw, adr, mw, irw, res, sa, sbb, imm, rw, alu, ill};
   endfunction

   // Immediate format by instruction class.
   function automatic logic [1:0] imm_ref(input logic [6:0] o);
      if (o == SW) return 2'b01;
      if (o == BQ) return 2'b10;
      if (o == JL) return 2'b11;
      return 2'b00;
   endfunction

   // ALU function by mnemonic: add/sub, slt, or, and; anything else adds.
   function automatic logic [2:0] alu_ref(input logic [6:0] o,
      input logic [2:0] f3, input logic f7);
      if (f3 == 3'b000) return (o == RT && f7) ? 3'b001 : 3'b000;
      if (f3 == 3'b010) return 3'b101;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
      return 3'b000;
   endfunction

   function automatic logic get_mr(input int n, input int k);
      if (n < 0) return ($urandom_range(0, 2) != 0) || (k >= 6);
      return k >= n;
   endfunction

   task automatic step(input logic [16:0] ex, input logic [16:0] m,
                       input string tag);
      exp_t e;
      e.exp = ex;
      e.msk = m;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input string nm);
      logic [1:0] im;
      logic       mr;
      int         k;
      op = o; funct3 = f3; funct7b5 = f7; zero = z; reset = 1'b0;
      im = imm_ref(o);
      k = 0;
      do begin
         mr = get_mr(fetch_stalls, k);
         mem_ready = mr;
         step(mk(mr,0,0,mr,2'b10,2'b00,2'b10,im,0,3'b000,0), ALL, {nm, ".fetch"});
         k++;
      end while (!mr);
      mem_ready = 1'($urandom);
      step(mk(0,0,0,0,2'b00,2'b01,2'b01,im,0,3'b000,0), ALL, {nm, ".decode"});
      if (o == LW || o == SW) begin
         mem_ready = 1'($urandom);
         step(mk(0,0,0,0,2'b00,2'b10,2'b01,im,0,3'b000,0), ALL, {nm, ".memadr"});
         k = 0;
         do begin
            mr = get_mr(mem_stalls, k);
            mem_ready = mr;
            if (o == LW)
               step(mk(0,1,0,0,2'b00,2'b00,2'b00,im,0,3'b000,0), ALL, {nm, ".memread"});
            else
               step(mk(0,1,1,0,2'b00,2'b00,2'b00,im,0,3'b000,0), ALL, {nm, ".memwrite"});
            k++;
         end while (!mr);
         if (o == LW)
            step(mk(0,0,0,0,2'b01,2'b00,2'b00,im,1,3'b000,0), ALL, {nm, ".memwb"});
      end else if (o == RT || o == IT) begin
         step(mk(0,0,0,0,2'b00,2'b10,(o == IT) ? 2'b01 : 2'b00,im,0,
                 alu_ref(o, f3, f7),0), ALL, {nm, ".execute"});
         step(mk(0,0,0,0,2'b00,2'b00,2'b00,im,1,3'b000,0), ALL, {nm, ".aluwb"});
      end else if (o == BQ) begin
         step(mk(z,0,0,0,2'b00,2'b10,2'b00,im,0,3'b001,0), ALL, {nm, ".beq"});
      end else if (o == JL) begin
         step(mk(1,0,0,0,2'b00,2'b01,2'b10,im,0,3'b000,0), ALL, {nm, ".jal"});
         step(mk(0,0,0,0,2'b00,2'b00,2'b00,im,1,3'b000,0), ALL, {nm, ".aluwb"});
      end else begin
         step(mk(0,0,0,0,2'b00,2'b00,2'b00,im,0,3'b000,1), ALL, {nm, ".illegal"});
      end
   endtask

   initial begin
      logic [6:0] rop;
      int         kind;
      reset = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0;
      zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      // Reset held for two cycles: no enable may be asserted.
      step(17'd0, EN_MASK, "reset0");
      step(17'd0, EN_MASK, "reset1");

      // Directed instructions; first fetch follows reset release directly.
      run_instr(LW, 3'b010, 1'b0, 1'b0, "lw");
      run_instr(RT, 3'b000, 1'b1, 1'b0, "sub");
      run_instr(IT, 3'b000, 1'b1, 1'b0, "addi_f7");
      run_instr(RT, 3'b010, 1'b0, 1'b0, "slt");
      run_instr(IT, 3'b110, 1'b0, 1'b0, "ori");
      run_instr(RT, 3'b111, 1'b0, 1'b0, "and");
      run_instr(BQ, 3'b000, 1'b0, 1'b1, "beq_taken");
      run_instr(BQ, 3'b000, 1'b0, 1'b0, "beq_not");
      run_instr(JL, 3'b000, 1'b0, 1'b0, "jal");
      mem_stalls = 3;
      run_instr(SW, 3'b010, 1'b0, 1'b0, "sw_stall");
      mem_stalls = -1;
      fetch_stalls = 2;
      run_instr(RT, 3'b000, 1'b0, 1'b0, "fetch_stall");
      fetch_stalls = -1;
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, "illegal");

      // Reset while waiting in MEMREAD: no writeback, restart at FETCH.
      fetch_stalls = 0;
      mem_stalls = 0;
      run_instr(LW, 3'b010, 1'b0, 1'b0, "lw_pre");
      op = LW; mem_ready = 1'b1;
      step(mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0), ALL, "rst_lw.fetch");
      step(mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0), ALL, "rst_lw.decode");
      step(mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0), ALL, "rst_lw.memadr");
      reset = 1'b1; mem_ready = 1'b1;
      step(mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0), ALL, "rst_lw.memread_rst");
      fetch_stalls = -1;
      mem_stalls = -1;
      run_instr(JL, 3'b000, 1'b0, 1'b0, "after_rst");

      // Random instruction stream with random memory stalls.
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 6);
         case (kind)
            0: rop = LW;
            1: rop = SW;
            2: rop = RT;
            3: rop = IT;
            4: rop = BQ;
            5: rop = JL;
            default: begin
               do rop = 7'($urandom);
               while (rop == LW || rop == SW || rop == RT || rop == IT ||
                      rop == BQ || rop == JL);
            end
         endcase
         run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), "rand");
      end

      // Let the monitor drain; anything left over is a missed comparison.
      repeat (2) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
